// File: rtl/q_value_update_pkg.sv
// Shared definitions for the Q-value update stage: memory map, word type,
// FSM state encodings and the Q-value saturation helper.
package q_value_update_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // Default memory map: count word, then 4-byte {ID, Q} entries.
    localparam word_t DEF_COUNT_ADDR = 16'h0040;
    localparam word_t DEF_TABLE_BASE = 16'h0042;
    localparam word_t ENTRY_STRIDE   = 16'd4;
    localparam word_t Q_FIELD_OFS    = 16'd2;

    // Q-value saturation limits, sized for the widest ALU intermediate.
    localparam logic signed [19:0] Q_MAX_W = 20'sd32767;
    localparam logic signed [19:0] Q_MIN_W = -20'sd32768;

    // FSM state encodings.
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RC_A = 4'd1;
    localparam logic [3:0] S_RC_D = 4'd2;
    localparam logic [3:0] S_ID_A = 4'd3;
    localparam logic [3:0] S_ID_D = 4'd4;
    localparam logic [3:0] S_Q_A  = 4'd5;
    localparam logic [3:0] S_Q_D  = 4'd6;
    localparam logic [3:0] S_CALC = 4'd7;
    localparam logic [3:0] S_WR   = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;

    // Request captured from selectMyAction when en is pulsed.
    typedef struct packed {
        word_t action;
        logic  agg;
        word_t reward;
    } upd_req_t;

    // Clamp a wide signed result into the 16-bit Q range.
    function automatic word_t sat_q(input logic signed [19:0] v);
        if (v > Q_MAX_W) begin
            return 16'h7FFF;
        end else if (v < Q_MIN_W) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/q_value_update_if.sv
// Control and memory bus of the Q-value update stage. The slave modport is
// the update block; the master modport is the controller / memory side.
interface q_value_update_if;
    logic        en;
    logic        start;
    logic [15:0] action;
    logic        forAggregation;
    logic [15:0] reward;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;
    logic [15:0] q_new;
    logic        not_found;
    logic        done;

    modport slave (
        input  en, start, action, forAggregation, reward, mem_data_in,
        output address, wr_en, mem_data_out, q_new, not_found, done
    );

    modport master (
        output en, start, action, forAggregation, reward, mem_data_in,
        input  address, wr_en, mem_data_out, q_new, not_found, done
    );
endinterface

// File: rtl/q_value_update_alu.sv
// Combinational Q-learning arithmetic:
//   q_new = sat(Q_old + ((reward + bonus + maxQ - Q_old) >>> ALPHA_SHIFT))
// Intermediates are widened one bit per add so nothing wraps before the
// final saturation.
module q_update_alu
    import q_value_update_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int AGG_BONUS   = 16
) (
    input  logic signed [15:0] reward_i,
    input  logic               agg_i,
    input  logic signed [15:0] maxq_i,
    input  logic signed [15:0] qold_i,
    output logic signed [15:0] q_new_o
);

    logic signed [16:0] r;
    logic signed [17:0] target;
    logic signed [18:0] diff;
    logic signed [18:0] delta;
    logic signed [19:0] sum;

    // Widen, accumulate, shift arithmetically, then saturate.
    always_comb begin
        r       = 17'(reward_i) + (agg_i ? 17'(AGG_BONUS) : 17'sd0);
        target  = 18'(r) + 18'(maxq_i);
        diff    = 19'(target) - 19'(qold_i);
        delta   = diff >>> ALPHA_SHIFT;
        sum     = 20'(qold_i) + 20'(delta);
        q_new_o = sat_q(sum);
    end

endmodule

// File: rtl/q_value_update.sv
// Q-learning update stage. Reads the neighbour table in one pass (count word,
// then ID/Q of each entry), tracks the first entry whose ID equals the latched
// action and the running signed maximum Q, computes the updated Q and writes
// it back to the matching entry. Memory read data arrives the cycle after the
// address, so every access is an *_A/*_D state pair holding the address.
module q_value_update
    import q_value_update_pkg::*;
#(
    parameter word_t COUNT_ADDR  = DEF_COUNT_ADDR,
    parameter word_t TABLE_BASE  = DEF_TABLE_BASE,
    parameter int    MAX_NEIGH   = 16,
    parameter int    ALPHA_SHIFT = 2,
    parameter int    AGG_BONUS   = 16
) (
    input  logic       clock,
    input  logic       nrst,
    q_value_update_if.slave bus
);

    localparam int            NW      = $clog2(MAX_NEIGH + 1);
    localparam logic [NW-1:0] IDX_ONE = NW'(1);
    localparam logic [NW-1:0] N_MAX   = NW'(MAX_NEIGH);

    logic [3:0]         state_q, state_d;
    upd_req_t           req_q;
    logic [NW-1:0]      idx_q, n_q, match_idx_q;
    logic               found_q, cur_match_q;
    logic signed [15:0] qold_q, maxq_q, q_new_q, alu_q;
    logic               not_found_q;

    logic [NW-1:0]      count_clamped;
    logic               last_entry;
    logic               id_hit;
    logic [15:0]        addr_d;
    logic               wr_en_d;

    // Table-scan helpers: clamped entry count, end of scan, first-match test.
    always_comb begin
        count_clamped = (bus.mem_data_in > 16'(MAX_NEIGH)) ? N_MAX
                                                           : NW'(bus.mem_data_in);
        last_entry    = (idx_q == n_q - IDX_ONE);
        id_hit        = !found_q && (bus.mem_data_in == req_q.action);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RC_A;
            S_RC_A: state_d = S_RC_D;
            S_RC_D: state_d = (count_clamped == '0) ? S_DONE : S_ID_A;
            S_ID_A: state_d = S_ID_D;
            S_ID_D: state_d = S_Q_A;
            S_Q_A:  state_d = S_Q_D;
            S_Q_D:  state_d = last_entry ? S_CALC : S_ID_A;
            S_CALC: state_d = S_WR;
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input latch: only accepted while idle so a run sees stable operands.
    always_ff @(posedge clock) begin
        if (nrst) begin
            req_q <= '0;
        end else if (state_q == S_IDLE && bus.en) begin
            req_q <= '{action: bus.action, agg: bus.forAggregation, reward: bus.reward};
        end
    end

    // Scan bookkeeping: entry index, count, first match and running max Q.
    always_ff @(posedge clock) begin
        if (nrst) begin
            idx_q       <= '0;
            n_q         <= '0;
            match_idx_q <= '0;
            found_q     <= 1'b0;
            cur_match_q <= 1'b0;
            qold_q      <= '0;
            maxq_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_q       <= '0;
                        match_idx_q <= '0;
                        found_q     <= 1'b0;
                        cur_match_q <= 1'b0;
                    end
                end
                S_RC_D: n_q <= count_clamped;
                S_ID_D: begin
                    // cur_match_q tells Q_D to capture this entry's Q as Q_old.
                    cur_match_q <= id_hit;
                    if (id_hit) begin
                        found_q     <= 1'b1;
                        match_idx_q <= idx_q;
                    end
                end
                S_Q_D: begin
                    if (cur_match_q) qold_q <= $signed(bus.mem_data_in);
                    if (idx_q == '0 || $signed(bus.mem_data_in) > maxq_q) begin
                        maxq_q <= $signed(bus.mem_data_in);
                    end
                    idx_q <= idx_q + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    // Result registers: q_new only moves on a hit; not_found is per run.
    always_ff @(posedge clock) begin
        if (nrst) begin
            q_new_q     <= '0;
            not_found_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) not_found_q <= 1'b0;
                S_RC_D: if (count_clamped == '0) not_found_q <= 1'b1;
                S_CALC: begin
                    if (found_q) q_new_q     <= alu_q;
                    else         not_found_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    q_update_alu #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .AGG_BONUS   (AGG_BONUS)
    ) u_alu (
        .reward_i (req_q.reward),
        .agg_i    (req_q.agg),
        .maxq_i   (maxq_q),
        .qold_i   (qold_q),
        .q_new_o  (alu_q)
    );

    // Bus address per state; held across each *_A/*_D pair.
    always_comb begin
        addr_d  = '0;
        wr_en_d = 1'b0;
        case (state_q)
            S_RC_A, S_RC_D: addr_d = COUNT_ADDR;
            S_ID_A, S_ID_D: addr_d = TABLE_BASE + ENTRY_STRIDE * 16'(idx_q);
            S_Q_A,  S_Q_D:  addr_d = TABLE_BASE + ENTRY_STRIDE * 16'(idx_q) + Q_FIELD_OFS;
            S_WR: begin
                if (found_q) begin
                    addr_d  = TABLE_BASE + ENTRY_STRIDE * 16'(match_idx_q) + Q_FIELD_OFS;
                    wr_en_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.address      = addr_d;
    assign bus.wr_en        = wr_en_d;
    assign bus.mem_data_out = wr_en_d ? q_new_q : '0;
    assign bus.q_new        = q_new_q;
    assign bus.not_found    = not_found_q;
    assign bus.done         = (state_q == S_DONE);

endmodule

// File: tb/tb_q_value_update.sv
// Bench for q_value_update: word-addressed memory models, a reference model
// that evaluates the Q-learning rule directly on the table contents, and one
// per-cycle compare process on the main instance. A second instance with
// ALPHA_SHIFT=0 covers saturation.
module tb_q_value_update;

    logic clock = 1'b0;
    logic nrst;
    always #5 clock = ~clock;

    q_value_update_if bus ();
    q_value_update_if bus_s ();

    q_value_update dut (.clock(clock), .nrst(nrst), .bus(bus));
    q_value_update #(.ALPHA_SHIFT(0)) dut_s (.clock(clock), .nrst(nrst), .bus(bus_s));

    logic [15:0] mem   [0:255];
    logic [15:0] mem_s [0:255];

    // Memories: registered read data, write on wr_en.
    always @(posedge clock) begin
        bus.mem_data_in <= mem[bus.address[8:1]];
        if (bus.wr_en) mem[bus.address[8:1]] <= bus.mem_data_out;
    end
    always @(posedge clock) begin
        bus_s.mem_data_in <= mem_s[bus_s.address[8:1]];
        if (bus_s.wr_en) mem_s[bus_s.address[8:1]] <= bus_s.mem_data_out;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] id_w(input int i);
        return 8'(33 + 2 * i);
    endfunction
    function automatic logic [7:0] q_w(input int i);
        return 8'(34 + 2 * i);
    endfunction

    // Reference-model state.
    logic [15:0] m_action, m_reward, m_qnew;
    bit          m_agg;
    int          exp_done;
    bit          exp_wr, exp_nf;
    logic [15:0] exp_addr, exp_data;

    bit          running = 1'b0;
    int          cyc;
    int          done_seen_cyc;
    int          n_writes = 0;
    logic [15:0] last_waddr;

    function automatic int floor_div_pow2(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Evaluate the update rule on the current table to get the expected run.
    task automatic predict();
        int n, hit, maxq, qold, r, res;
        n    = (mem[8'h20] > 16'd16) ? 16 : int'(mem[8'h20]);
        hit  = -1;
        maxq = 0;
        qold = 0;
        for (int i = 0; i < n; i++) begin
            int q;
            q = int'($signed(mem[q_w(i)]));
            if (i == 0 || q > maxq) maxq = q;
            if (hit < 0 && mem[id_w(i)] == m_action) begin
                hit  = i;
                qold = q;
            end
        end
        exp_done = (n == 0) ? 3 : 4 * n + 5;
        exp_wr   = (hit >= 0);
        exp_nf   = (hit < 0);
        exp_addr = '0;
        exp_data = '0;
        if (hit >= 0) begin
            r   = int'($signed(m_reward)) + (m_agg ? 16 : 0);
            res = qold + floor_div_pow2(r + maxq - qold, 2);
            if (res > 32767)  res = 32767;
            if (res < -32768) res = -32768;
            exp_data = 16'(res);
            exp_addr = 16'h0042 + 16'(4 * hit + 2);
            m_qnew   = exp_data;
        end
    endtask

    // Per-cycle compare of the main instance against the model.
    always @(negedge clock) begin
        if (running) begin
            cyc++;
            if (bus.done && done_seen_cyc < 0) done_seen_cyc = cyc;
            chk("done", 32'(bus.done), 32'(cyc == exp_done));
            chk("wr_en", 32'(bus.wr_en), 32'(exp_wr && cyc == exp_done - 1));
            if (bus.wr_en) begin
                chk("wr_addr", 32'(bus.address), 32'(exp_addr));
                chk("wr_data", 32'(bus.mem_data_out), 32'(exp_data));
                last_waddr = bus.address;
                n_writes++;
            end
            if (cyc == exp_done) begin
                chk("q_new", 32'(bus.q_new), 32'(m_qnew));
                chk("not_found", 32'(bus.not_found), 32'(exp_nf));
            end
        end else if (!nrst) begin
            chk("idle_done", 32'(bus.done), 32'(0));
            chk("idle_wr_en", 32'(bus.wr_en), 32'(0));
        end
    end

    task automatic load_table1();
        mem[8'h20] = 16'd3;
        mem[id_w(0)] = 16'd5;  mem[q_w(0)] = 16'd100;
        mem[id_w(1)] = 16'd9;  mem[q_w(1)] = 16'd300;
        mem[id_w(2)] = 16'd12; mem[q_w(2)] = 16'd200;
    endtask

    task automatic latch(input logic [15:0] a, input logic [15:0] r, input bit g);
        @(negedge clock);
        bus.en = 1'b1;
        bus.action = a;
        bus.reward = r;
        bus.forAggregation = g;
        m_action = a;
        m_reward = r;
        m_agg    = g;
        @(negedge clock);
        bus.en = 1'b0;
        bus.action = 16'($urandom);
        bus.reward = 16'($urandom);
        bus.forAggregation = 1'($urandom);
    endtask

    // One run; 'disturb' pulses start/en with other operands mid-run.
    task automatic run(input bit disturb);
        predict();
        done_seen_cyc = -1;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        cyc = 0;
        running = 1'b1;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.en    = 1'b0;
            if (disturb && k == 4 && exp_done > 6) begin
                bus.start = 1'b1;
                bus.en    = 1'b1;
                bus.action = m_action ^ 16'h0001;
                bus.reward = 16'($urandom);
                bus.forAggregation = ~m_agg;
            end
        end
        #1 running = 1'b0;
    endtask

    task automatic run_s(input logic [15:0] q, input logic [15:0] r,
                         input logic [15:0] expq, input string nm);
        int seen;
        mem_s[8'h20] = 16'd1;
        mem_s[8'h21] = 16'd3;
        mem_s[8'h22] = q;
        @(negedge clock);
        bus_s.en = 1'b1;
        bus_s.start = 1'b1;
        bus_s.action = 16'd3;
        bus_s.reward = r;
        bus_s.forAggregation = 1'b0;
        @(negedge clock);
        bus_s.en = 1'b0;
        bus_s.start = 1'b0;
        seen = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clock);
            if (bus_s.done) begin
                seen = k;
                break;
            end
        end
        chk({nm, "_done_cycle"}, 32'(seen), 32'(9));
        chk({nm, "_q_new"}, 32'(bus_s.q_new), 32'(expq));
        chk({nm, "_mem"}, 32'(mem_s[8'h22]), 32'(expq));
        @(negedge clock);
    endtask

    initial begin
        int w0;
        nrst = 1'b1;
        bus.en = 0; bus.start = 0; bus.action = 0; bus.reward = 0; bus.forAggregation = 0;
        bus_s.en = 0; bus_s.start = 0; bus_s.action = 0; bus_s.reward = 0; bus_s.forAggregation = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            mem_s[i] = '0;
        end
        m_qnew = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nrst = 1'b0;

        // Reset state.
        chk("rst_address", 32'(bus.address), 32'(0));
        chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
        chk("rst_mem_data_out", 32'(bus.mem_data_out), 32'(0));
        chk("rst_q_new", 32'(bus.q_new), 32'(0));
        chk("rst_not_found", 32'(bus.not_found), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_s_q_new", 32'(bus_s.q_new), 32'(0));

        // Basic update.
        load_table1();
        latch(16'd9, 16'd40, 1'b0);
        w0 = n_writes;
        run(1'b0);
        chk("t1_model_done", 32'(exp_done), 32'(17));
        chk("t1_model_q", 32'(exp_data), 32'(310));
        chk("t1_done_cycle", 32'(done_seen_cyc), 32'(17));
        chk("t1_q_new", 32'(bus.q_new), 32'(310));
        chk("t1_waddr", 32'(last_waddr), 32'(16'h0048));
        chk("t1_nwrites", 32'(n_writes - w0), 32'(1));
        chk("t1_mem", 32'(mem[q_w(1)]), 32'(310));

        // Aggregation bonus.
        load_table1();
        latch(16'd5, 16'd40, 1'b1);
        run(1'b0);
        chk("t2_q_new", 32'(bus.q_new), 32'(164));
        chk("t2_waddr", 32'(last_waddr), 32'(16'h0044));
        chk("t2_done_cycle", 32'(done_seen_cyc), 32'(17));

        // Action absent: no write, q_new holds.
        load_table1();
        latch(16'd7, 16'd40, 1'b0);
        w0 = n_writes;
        run(1'b0);
        chk("t3_nwrites", 32'(n_writes - w0), 32'(0));
        chk("t3_not_found", 32'(bus.not_found), 32'(1));
        chk("t3_q_new_hold", 32'(bus.q_new), 32'(164));
        chk("t3_done_cycle", 32'(done_seen_cyc), 32'(17));

        // Saturation, both directions, on the ALPHA_SHIFT=0 instance.
        run_s(16'd32760, 16'd32767, 16'h7FFF, "sat_hi");
        run_s(16'hE008, 16'h8000, 16'h8000, "sat_lo");

        // Empty table.
        mem[8'h20] = 16'd0;
        latch(16'd5, 16'd1, 1'b0);
        w0 = n_writes;
        run(1'b0);
        chk("t5_done_cycle", 32'(done_seen_cyc), 32'(3));
        chk("t5_not_found", 32'(bus.not_found), 32'(1));
        chk("t5_nwrites", 32'(n_writes - w0), 32'(0));

        // Reset mid-run, then a clean run.
        load_table1();
        latch(16'd9, 16'd40, 1'b0);
        predict();
        w0 = n_writes;
        done_seen_cyc = -1;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        cyc = 0;
        running = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        #1 running = 1'b0;
        nrst = 1'b1;
        @(negedge clock);
        #1 nrst = 1'b0;
        m_qnew = '0;
        chk("mid_rst_q_new", 32'(bus.q_new), 32'(0));
        chk("mid_rst_done", 32'(bus.done), 32'(0));
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'(0));
        repeat (20) @(negedge clock);
        chk("mid_rst_nwrites", 32'(n_writes - w0), 32'(0));
        latch(16'd9, 16'd40, 1'b0);
        run(1'b0);
        chk("post_rst_q_new", 32'(bus.q_new), 32'(310));
        chk("post_rst_done_cycle", 32'(done_seen_cyc), 32'(17));

        // Busy start/en ignored.
        load_table1();
        latch(16'd9, 16'd40, 1'b0);
        run(1'b1);
        chk("busy_q_new", 32'(bus.q_new), 32'(310));
        chk("busy_done_cycle", 32'(done_seen_cyc), 32'(17));

        // Randomised tables and operands.
        for (int t = 0; t < 40; t++) begin
            mem[8'h20] = 16'($urandom_range(0, 20));
            for (int i = 0; i < 20; i++) begin
                mem[id_w(i)] = 16'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       mem[q_w(i)] = 16'h7FFF - 16'($urandom_range(0, 50));
                    1:       mem[q_w(i)] = 16'h8000 + 16'($urandom_range(0, 50));
                    default: mem[q_w(i)] = 16'($urandom);
                endcase
            end
            latch(16'($urandom_range(0, 9)),
                  ($urandom_range(0, 3) == 0) ? 16'h7FF0 : 16'($urandom),
                  1'($urandom));
            run(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q_value_update.md
Name: q_value_update

Overview:
- Downstream stage of selectMyAction. Consumes the chosen `action` (neighbour ID) and the `forAggregation` flag, then performs one Q-learning update on that neighbour's Q-value in the neighbour table in shared memory.
- In one pass over the table it finds the matching entry and the maximum Q, computes the new Q, and writes it back. It then pulses `done` to the node controller.

Parameters:
- COUNT_ADDR, 16'h0040, byte address of the neighbour-count word
- TABLE_BASE, 16'h0042, byte address of entry 0. Entry i: ID at TABLE_BASE+4i, Q at TABLE_BASE+4i+2.
- MAX_NEIGH, 16, the count word is clamped to this value
- ALPHA_SHIFT, 2, learning rate = 2^-ALPHA_SHIFT
- AGG_BONUS, 16, signed value added to reward when forAggregation=1

Ports:
- clock  in  1  system clock, rising edge
- nrst  in  1  synchronous reset, active-high (nrst=1 at a rising edge resets)
- en  in  1  latch action, forAggregation, reward into internal registers
- start  in  1  begin update, sampled only in IDLE
- action  in  16  neighbour ID from selectMyAction
- forAggregation  in  1  from selectMyAction
- reward  in  16  signed reward
- address  out  16  memory byte address
- wr_en  out  1  memory write strobe
- mem_data_out  out  16  write data to memory
- mem_data_in  in  16  read data from memory, valid the cycle after address is driven
- q_new  out  16  signed updated Q value
- not_found  out  1  action was absent from the table on the last run
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; latched regs 0.
- Reset priority: nrst overrides everything, including mid-operation. The FSM returns to IDLE, wr_en is 0 from the next cycle, and no done pulse is issued.
- Latch rule: en=1 latches inputs. If en=1 while busy, nothing is latched.
- Start rule: start=1 in IDLE begins a run. start while busy is ignored.
- States and transitions:
  - IDLE
  - RC_A: address=COUNT_ADDR
  - RC_D: capture N=min(count, MAX_NEIGH); go to DONE if N=0
  - Per entry i: ID_A, ID_D, Q_A, Q_D
  - CALC
  - WR
  - DONE
  - back to IDLE
- ID_D: if mem_data_in==action and no match yet, record index i and Q_old. The first match wins.
- Q_D: update maxQ as a signed compare; maxQ is initialised from entry 0.
- CALC arithmetic:
  - r = reward + (forAggregation ? AGG_BONUS : 0), 17-bit signed
  - target = r + maxQ, 18-bit
  - diff = target - Q_old, 19-bit
  - delta = diff >>> ALPHA_SHIFT (arithmetic shift)
  - q_new = saturate(Q_old + delta) to [-32768, 32767]
- WR: if a match was found, wr_en=1 for exactly one cycle with address=TABLE_BASE+4*idx+2 and mem_data_out=q_new. If no match, wr_en stays 0, not_found=1 and q_new holds its previous value.
- Timing:
  - N>=1: done high in cycle 4N+5 after the start edge.
  - N=0: done in cycle 3, not_found=1, no write.
- Bus rules: wr_en=0 in every read state. address is stable throughout each *_A/*_D pair.
- not_found is cleared at the start of each run.

Decomposition:
- Shared defines include:
  - WORD_WIDTH=16
  - memory map constants (COUNT_ADDR, TABLE_BASE, entry stride 4)
  - FSM state encodings
  - Q saturation limits
- One sub-module: q_update_alu. It is combinational and takes reward, forAggregation, maxQ and Q_old, and produces the saturated q_new. It is instantiated in CALC.

Test Plan:
- Basic update. Table: count=3, IDs {5,9,12}, Q {100,300,200}; action=9, reward=40, forAgg=0. Required: one write of 310 to 0x0048, q_new=310, done at cycle 17, not_found=0.
- Aggregation bonus. Same table; action=5, reward=40, forAgg=1. Required: q_new=164 written to 0x0044, done at cycle 17.
- Action not in table. action=7. Required: no wr_en at any cycle, not_found=1, done at cycle 17.
- Saturation. Table: count=1, ID 3, Q 32760; action=3, reward=32767, ALPHA_SHIFT=0 instance. Required: q_new=32767 (saturated).
- Empty table. count=0. Required: done at cycle 3, not_found=1, no write.
- Robustness, in two parts:
  - Reset mid-run: nrst=1 at cycle 6 of a run → IDLE, no done, no write. A following run completes normally.
  - Busy start: start asserted while busy → ignored.
